// File: rtl/decode_stage_if.sv
// Fetch-side and register-read-side handshake bundle for decode_stage.
// No storage; pure wiring.
// Both directions use valid/ready; master drives in_* and out_ready.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_copro;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_type, out_copro
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_type, out_copro
    );
endinterface

// File: rtl/decode_stage.sv
// RISC-V decode stage: field split, format classify, immediate build, custom-0 coprocessor flag.
// Latency 1 cycle, 1 instr/cycle sustained; in_ready comes straight from a flop.
// Backpressure absorbed by a 2-entry head/skid buffer. Build option DECODE_ILLEGAL_PASS_EN forwards illegal encodings.
module decode_stage #(
    parameter int          XLEN          = 32,
    parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011,
    parameter logic [63:0] RESET_PC      = 64'd0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_CUSTOM  = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            copro;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

`ifdef DECODE_ILLEGAL_PASS_EN
    localparam bit PASS_ILLEGAL = 1'b1;
`else
    localparam bit PASS_ILLEGAL = 1'b0;
`endif

    // Standard opcodes take precedence should CUSTOM_OPCODE ever alias one.
    function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t      e;
        logic [31:0] imm32;
        e        = '0;
        imm32    = '0;
        e.pc     = pc;
        e.opcode = instr[6:0];
        e.rd     = instr[11:7];
        e.funct3 = instr[14:12];
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.funct7 = instr[31:25];
        e.fmt    = FMT_ILLEGAL;
        e.copro  = 1'b0;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                7'b0110011: e.fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    e.fmt = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                7'b0100011: begin
                    e.fmt = FMT_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                7'b1100011: begin
                    e.fmt = FMT_B;
                    imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    e.fmt = FMT_U;
                    imm32 = {instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    e.fmt = FMT_J;
                    imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: begin
                    if (instr[6:0] == CUSTOM_OPCODE) begin
                        e.fmt   = FMT_CUSTOM;
                        e.copro = 1'b1;
                    end
                end
            endcase
        end
        e.imm = XLEN'($signed(imm32));
        return e;
    endfunction

    state_t state_q, state_d;
    logic   in_ready_q, out_valid_q;
    entry_t head_q, skid_q;
    entry_t in_dec;
    logic   accept, keep, emit;
    logic   load_head_in, load_head_skid, load_skid;

    always_comb begin
        in_dec = decode(bus.in_instr, bus.in_pc);
        accept = bus.in_valid & in_ready_q;
        keep   = accept & (PASS_ILLEGAL | (in_dec.fmt != FMT_ILLEGAL));
        emit   = out_valid_q & bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (keep) begin
                        state_d      = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (keep && emit) begin
                        load_head_in = 1'b1;
                    end else if (keep) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d        = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Data registers only move on loads, so outputs hold while empty or flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            head_q.pc <= RESET_PC[XLEN-1:0];
            skid_q    <= '0;
        end else begin
            if (load_head_in) begin
                head_q <= in_dec;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_dec;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = head_q.pc;
    assign bus.out_opcode = head_q.opcode;
    assign bus.out_rd     = head_q.rd;
    assign bus.out_funct3 = head_q.funct3;
    assign bus.out_rs1    = head_q.rs1;
    assign bus.out_rs2    = head_q.rs2;
    assign bus.out_funct7 = head_q.funct7;
    assign bus.out_imm    = head_q.imm;
    assign bus.out_type   = head_q.fmt;
    assign bus.out_copro  = head_q.copro;

endmodule
